// File: rtl/psc_pkg.sv
// Shared types, limits and the round-robin pick function for pattern_scan_sched.
package psc_pkg;

  // Scheduler FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } psc_state_t;

  // Largest supported requester count and pattern length.
  localparam int PSC_MAX_NREQ  = 4;
  localparam int PSC_MAX_PAT_W = 8;

  // Width of a requester index at the largest supported requester count.
  localparam int PSC_ID_W = 2;

  // Returns the first requester with valid set, searching circularly from
  // the one after 'last'. When nothing is valid, 'last' comes back unchanged;
  // the caller only uses the result when at least one request is valid.
  function automatic logic [PSC_ID_W-1:0] rr_next(
    input logic [PSC_MAX_NREQ-1:0] valid,
    input logic [PSC_ID_W-1:0]     last,
    input int                      nreq
  );
    logic [PSC_ID_W-1:0]     pick;
    logic                    found;
    logic [PSC_MAX_NREQ-1:0] rot;
    int                      idx;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= PSC_MAX_NREQ; i++) begin
      idx = (int'(last) + i) % nreq;
      rot = valid >> idx;
      if (!found && (i <= nreq) && rot[0]) begin
        pick  = idx[PSC_ID_W-1:0];
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/psc_bit_matcher.sv
// Serial Mealy pattern matcher: keeps the recent-bit history, flags a match
// on the current bit and counts matches (saturating). A start pulse empties
// the history and clears the count, so matches never span two words.
// Macro PSC_OVERLAP_EN: when defined, the history is kept after a match so
// overlapping occurrences are counted; otherwise it is emptied after a match.
module psc_bit_matcher #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic [PAT_W-1:0] pattern,
  output logic             det,
  output logic [CNT_W-1:0] match_count
);
  import psc_pkg::*;

  // Fill counter is sized for the longest supported pattern.
  localparam int                 HLEN_W    = $clog2(psc_pkg::PSC_MAX_PAT_W);
  localparam logic [HLEN_W-1:0]  HLEN_FULL = HLEN_W'(PAT_W - 1);
  localparam logic [PAT_W-2:0]   HIST_CLR  = {(PAT_W-1){1'b0}};
  localparam logic [HLEN_W-1:0]  FILL_CLR  = {HLEN_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_CLR   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_MAX   = {CNT_W{1'b1}};

  logic [PAT_W-2:0]  hist_r;
  logic [HLEN_W-1:0] fill_r;
  logic [CNT_W-1:0]  count_r;
  logic              full_s;
  logic              det_s;
  logic [PAT_W-1:0]  shifted_s;

  // Match decode: the history must hold PAT_W-1 real bits of this word,
  // equal to the upper pattern bits, and the current bit the pattern LSB.
  always_comb begin
    full_s    = (fill_r == HLEN_FULL);
    shifted_s = {hist_r, bit_in};
    if (shift_en && full_s) begin
      det_s = (bit_in == pattern[0]) && (hist_r == pattern[PAT_W-1:1]);
    end else begin
      det_s = 1'b0;
    end
  end

  // History, fill level and saturating match count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_r  <= HIST_CLR;
      fill_r  <= FILL_CLR;
      count_r <= CNT_CLR;
    end else if (start) begin
      hist_r  <= HIST_CLR;
      fill_r  <= FILL_CLR;
      count_r <= CNT_CLR;
    end else if (shift_en) begin
`ifdef PSC_OVERLAP_EN
      hist_r <= shifted_s[PAT_W-2:0];
      fill_r <= full_s ? fill_r : (fill_r + HLEN_W'(1));
`else
      if (det_s) begin
        hist_r <= HIST_CLR;
        fill_r <= FILL_CLR;
      end else begin
        hist_r <= shifted_s[PAT_W-2:0];
        fill_r <= full_s ? fill_r : (fill_r + HLEN_W'(1));
      end
`endif
      if (det_s && (count_r != CNT_MAX)) begin
        count_r <= count_r + CNT_W'(1);
      end
    end
  end

  assign det         = det_s;
  assign match_count = count_r;

endmodule

// File: rtl/pattern_scan_sched.sv
// Round-robin scheduler sharing one serial pattern matcher among NREQ
// requesters. A granted word is scanned MSB-first, one bit per clock, and
// the match count is reported tagged with the requester id.
// Macro PSC_OVERLAP_EN selects overlapping match counting in the matcher.
module pattern_scan_sched #(
  parameter int               NREQ    = 2,
  parameter int               WORD_W  = 8,
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1011,
  parameter int               CNT_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [PAT_W-1:0]         cfg_pattern,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*WORD_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(NREQ)-1:0]  res_id,
  output logic [CNT_W-1:0]         res_count,
  output logic                     det,
  output logic                     busy
);
  import psc_pkg::*;

  localparam int                   ID_W        = $clog2(NREQ);
  localparam int                   BIT_CNT_W   = $clog2(WORD_W);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT    = BIT_CNT_W'(WORD_W - 1);
  localparam logic [BIT_CNT_W-1:0] BIT_CLR     = {BIT_CNT_W{1'b0}};
  localparam logic [ID_W-1:0]      RR_LAST_RST = ID_W'(NREQ - 1);
  localparam logic [ID_W-1:0]      ID_CLR      = {ID_W{1'b0}};
  localparam logic [NREQ-1:0]      GRANT_LSB   = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [NREQ-1:0]      READY_CLR   = {NREQ{1'b0}};
  localparam logic [WORD_W-1:0]    WORD_CLR    = {WORD_W{1'b0}};
  localparam logic [CNT_W-1:0]     CNT_CLR     = {CNT_W{1'b0}};

  psc_state_t           state_r;
  psc_state_t           state_nxt_s;
  logic [ID_W-1:0]      grant_idx_s;
  logic                 grant_fire_s;
  logic                 shift_en_s;
  logic [ID_W-1:0]      rr_last_r;
  logic [ID_W-1:0]      id_r;
  logic [WORD_W-1:0]    word_r;
  logic [BIT_CNT_W-1:0] bit_cnt_r;
  logic [PAT_W-1:0]     pattern_r;
  logic                 res_valid_r;
  logic [ID_W-1:0]      res_id_r;
  logic [CNT_W-1:0]     res_count_r;
  logic                 det_s;
  logic [CNT_W-1:0]     match_count_s;

  // Round-robin choice among the currently valid requesters.
  always_comb begin
    grant_idx_s = ID_W'(rr_next(PSC_MAX_NREQ'(req_valid), PSC_ID_W'(rr_last_r), NREQ));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and control strobes.
  always_comb begin
    state_nxt_s  = state_r;
    grant_fire_s = 1'b0;
    shift_en_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (|req_valid) begin
          grant_fire_s = 1'b1;
          state_nxt_s  = SHIFT;
        end else begin
          state_nxt_s  = IDLE;
        end
      end
      SHIFT: begin
        shift_en_s = 1'b1;
        if (bit_cnt_r == LAST_BIT) begin
          state_nxt_s = REPORT;
        end else begin
          state_nxt_s = SHIFT;
        end
      end
      REPORT: begin
        if (res_valid_r && res_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = REPORT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // One-hot accept pulse; held off while reset is asserted so a waiting
  // requester never sees an accept that the reset is about to discard.
  always_comb begin
    req_ready = READY_CLR;
    if (grant_fire_s && rst_n) begin
      req_ready = GRANT_LSB << grant_idx_s;
    end else begin
      req_ready = READY_CLR;
    end
  end

  // Word capture at grant, then MSB-first shifting with a bit position count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_r    <= WORD_CLR;
      bit_cnt_r <= BIT_CLR;
      id_r      <= ID_CLR;
      rr_last_r <= RR_LAST_RST;
    end else if (grant_fire_s) begin
      word_r    <= req_data[int'(grant_idx_s)*WORD_W +: WORD_W];
      bit_cnt_r <= BIT_CLR;
      id_r      <= grant_idx_s;
      rr_last_r <= grant_idx_s;
    end else if (shift_en_s) begin
      word_r    <= {word_r[WORD_W-2:0], 1'b0};
      bit_cnt_r <= bit_cnt_r + BIT_CNT_W'(1);
    end
  end

  // Pattern register: writable only while idle, so a write landing together
  // with a grant already applies to that grant's scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_r <= PAT_RST;
    end else if ((state_r == IDLE) && cfg_we) begin
      pattern_r <= cfg_pattern;
    end
  end

  // Result registers: captured on the first REPORT cycle, held until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_r <= 1'b0;
      res_id_r    <= ID_CLR;
      res_count_r <= CNT_CLR;
    end else if (state_r == REPORT) begin
      if (!res_valid_r) begin
        res_valid_r <= 1'b1;
        res_id_r    <= id_r;
        res_count_r <= match_count_s;
      end else if (res_ready) begin
        res_valid_r <= 1'b0;
      end
    end else begin
      res_valid_r <= 1'b0;
    end
  end

  psc_bit_matcher #(
    .PAT_W (PAT_W),
    .CNT_W (CNT_W)
  ) u_matcher (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (grant_fire_s),
    .shift_en    (shift_en_s),
    .bit_in      (word_r[WORD_W-1]),
    .pattern     (pattern_r),
    .det         (det_s),
    .match_count (match_count_s)
  );

  assign det       = det_s;
  assign busy      = (state_r != IDLE);
  assign res_valid = res_valid_r;
  assign res_id    = res_id_r;
  assign res_count = res_count_r;

endmodule

// File: tb/tb_pattern_scan_sched.sv
// Directed, table-driven bench for pattern_scan_sched (default parameters).
module tb_pattern_scan_sched;

`ifdef PSC_OVERLAP_EN
  localparam bit OV = 1'b1;
`else
  localparam bit OV = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        cfg_we;
  logic [3:0]  cfg_pattern;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic [0:0]  res_id;
  logic [3:0]  res_count;
  logic        det;
  logic        busy;

  int checks = 0;
  int errors = 0;

  pattern_scan_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_count   (res_count),
    .det         (det),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] data;
    logic [3:0] pat;
    int         hold;
    logic [3:0] cnt_ov;
    logic [3:0] cnt_no;
  } vec_t;

  vec_t tbl[7];

  function automatic logic [3:0] ex(input logic [3:0] ov, input logic [3:0] no);
    return OV ? ov : no;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge while idle; one-cycle pattern write.
  task automatic write_cfg(input logic [3:0] pat);
    cfg_we      = 1'b1;
    cfg_pattern = pat;
    @(negedge clk);
    cfg_we      = 1'b0;
  endtask

  // Called at a negedge while idle; runs one word through and consumes it.
  task automatic do_job(input int id, input logic [7:0] data, input int hold,
                        input logic cfg_now, input logic [3:0] cfg_pat,
                        input logic mid_cfg, input logic [3:0] exp_cnt,
                        input string tag);
    int         n;
    int         lat;
    logic       det_seen;
    logic [1:0] exp_rdy;
    exp_rdy = 2'b01 << id;
    req_data = 16'h0000;
    req_data[id*8 +: 8] = data;
    req_valid = exp_rdy;
    if (cfg_now) begin
      cfg_we      = 1'b1;
      cfg_pattern = cfg_pat;
    end
    #1;
    n = 0;
    while (req_ready == 2'b00 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_grant"}, req_ready, exp_rdy);
    @(posedge clk); #1;
    req_valid = 2'b00;
    cfg_we    = 1'b0;
    chk({tag, "_busy"}, busy, 1'b1);
    lat = 0;
    det_seen = 1'b0;
    while (!res_valid && lat < 40) begin
      if (det) det_seen = 1'b1;
      if (mid_cfg && lat == 2) begin
        cfg_we      = 1'b1;
        cfg_pattern = 4'b1111;
      end else if (lat == 3) begin
        cfg_we = 1'b0;
      end
      @(posedge clk); #1; lat++;
    end
    cfg_we = 1'b0;
    chk({tag, "_res_valid"}, res_valid, 1'b1);
    chk({tag, "_latency"}, lat, 9);
    chk({tag, "_res_id"}, res_id, id);
    chk({tag, "_res_count"}, res_count, exp_cnt);
    chk({tag, "_det_seen"}, det_seen, (exp_cnt != 4'd0));
    if (hold > 0) req_valid = 2'b11;
    for (int h = 0; h < hold; h++) begin
      chk({tag, "_hold_valid"}, res_valid, 1'b1);
      chk({tag, "_hold_id"}, res_id, id);
      chk({tag, "_hold_count"}, res_count, exp_cnt);
      chk({tag, "_hold_no_ready"}, req_ready, 2'b00);
      @(posedge clk); #1;
    end
    @(negedge clk);
    req_valid = 2'b00;
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_res_taken"}, res_valid, 1'b0);
  endtask

  initial begin
    int n;
    tbl[0] = '{0, 8'b1011_0110, 4'b1011, 0, 4'd2, 4'd1};
    tbl[1] = '{1, 8'h00,        4'b1011, 0, 4'd0, 4'd0};
    tbl[2] = '{0, 8'b1011_1011, 4'b1011, 5, 4'd2, 4'd2};
    tbl[3] = '{1, 8'b0101_1011, 4'b1011, 0, 4'd2, 4'd1};
    tbl[4] = '{0, 8'h00,        4'b0000, 0, 4'd5, 4'd2};
    tbl[5] = '{1, 8'hFF,        4'b1111, 0, 4'd5, 4'd2};
    tbl[6] = '{0, 8'b0110_1101, 4'b0110, 0, 4'd2, 4'd1};

    rst_n = 1'b1; cfg_we = 1'b0; cfg_pattern = 4'b0000;
    req_valid = 2'b00; req_data = 16'h0000; res_ready = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_res_id", res_id, 1'b0);
    chk("rst_res_count", res_count, 4'd0);
    chk("rst_det", det, 1'b0);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table of single-requester words.
    for (int i = 0; i < 7; i++) begin
      write_cfg(tbl[i].pat);
      do_job(tbl[i].id, tbl[i].data, tbl[i].hold, 1'b0, 4'b0000, 1'b0,
             ex(tbl[i].cnt_ov, tbl[i].cnt_no), $sformatf("vec%0d", i));
    end

    // Pattern write during SHIFT is dropped; write together with grant applies.
    write_cfg(4'b1011);
    do_job(0, 8'b1011_0110, 0, 1'b0, 4'b0000, 1'b1, ex(4'd2, 4'd1), "cfg_mid");
    do_job(1, 8'hFF, 0, 1'b0, 4'b0000, 1'b0, 4'd0, "cfg_after");
    do_job(0, 8'hFF, 0, 1'b1, 4'b1111, 1'b0, ex(4'd5, 4'd2), "cfg_same");

    // Reset in the middle of a scan.
    req_data  = 16'h00FF;
    req_valid = 2'b01;
    @(posedge clk); #1;
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #3;
    chk("mid_busy", busy, 1'b1);
    chk("mid_det", det, 1'b1);
    req_data  = {8'h00, 8'b1011_0110};
    req_valid = 2'b11;
    rst_n     = 1'b0;
    #1;
    chk("arst_busy", busy, 1'b0);
    chk("arst_det", det, 1'b0);
    chk("arst_res_valid", res_valid, 1'b0);
    chk("arst_res_count", res_count, 4'd0);
    chk("arst_req_ready", req_ready, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;

    // Both requesters valid continuously: grants alternate from 0.
    for (int j = 0; j < 4; j++) begin
      #1;
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
        @(negedge clk); #1; n++;
      end
      chk($sformatf("rr_grant%0d", j), req_ready, (j % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk); #1;
      chk($sformatf("rr_pulse%0d", j), req_ready, 2'b00);
      n = 0;
      while (!res_valid && n < 40) begin
        @(posedge clk); #1; n++;
      end
      chk($sformatf("rr_id%0d", j), res_id, j % 2);
      chk($sformatf("rr_count%0d", j), res_count, (j % 2 == 0) ? ex(4'd2, 4'd1) : 4'd0);
      @(negedge clk);
      res_ready = 1'b1;
      @(negedge clk);
      res_ready = 1'b0;
    end
    req_valid = 2'b00;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
